// File: rtl/rsa_encrypt_core.sv
// RSA encryption engine: cipher = msg^E mod N by right-to-left square-and-multiply,
// one modular multiply/square step per clock behind a start/busy/done handshake.
module rsa_encrypt_core #(
    parameter int          WIDTH = 8,
    parameter int unsigned E     = 7,
    parameter int unsigned N     = 143
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] msg,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] cipher,
    output logic             err
);

    // Bit length of the exponent: index of the highest set bit plus one.
    function automatic int ebits_f(input int unsigned e);
        int n;
        n = 0;
        for (int i = 0; i < 32; i++) begin
            if (e[i]) begin
                n = i + 1;
            end else begin
                n = n;
            end
        end
        return n;
    endfunction

    localparam int                 EBITS   = ebits_f(E);
    localparam logic [WIDTH-1:0]   E_W     = WIDTH'(E);
    localparam logic [WIDTH-1:0]   N_W     = WIDTH'(N);
    localparam logic [2*WIDTH-1:0] N_2W    = (2 * WIDTH)'(N);
    localparam logic [WIDTH-1:0]   ONE_W   = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0]   ONE_MOD = (N == 32'd1) ? {WIDTH{1'b0}} : ONE_W;

    // Full double-width product, reduced only after the multiply.
    function automatic logic [WIDTH-1:0] modmul_f(input logic [WIDTH-1:0] a,
                                                  input logic [WIDTH-1:0] b);
        logic [2*WIDTH-1:0] p;
        p = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
        return WIDTH'(p % N_2W);
    endfunction

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_STEP = 1'b1
    } state_t;

    state_t           state_r, state_s;
    logic [WIDTH-1:0] acc_r, acc_s;
    logic [WIDTH-1:0] base_r, base_s;
    logic [WIDTH-1:0] exp_r, exp_s;
    logic [WIDTH-1:0] acc_step_s;
    logic             busy_s;
    logic             done_s;
    logic [WIDTH-1:0] cipher_s;
    logic             err_s;

    // State, datapath and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            acc_r   <= {WIDTH{1'b0}};
            base_r  <= {WIDTH{1'b0}};
            exp_r   <= {WIDTH{1'b0}};
            busy    <= 1'b0;
            done    <= 1'b0;
            cipher  <= {WIDTH{1'b0}};
            err     <= 1'b0;
        end else begin
            state_r <= state_s;
            acc_r   <= acc_s;
            base_r  <= base_s;
            exp_r   <= exp_s;
            busy    <= busy_s;
            done    <= done_s;
            cipher  <= cipher_s;
            err     <= err_s;
        end
    end

    // Next-state and datapath update for the square-and-multiply loop.
    always_comb begin
        state_s    = state_r;
        acc_s      = acc_r;
        base_s     = base_r;
        exp_s      = exp_r;
        busy_s     = busy;
        done_s     = 1'b0;
        cipher_s   = cipher;
        err_s      = err;
        acc_step_s = exp_r[0] ? modmul_f(acc_r, base_r) : acc_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    if (msg >= N_W) begin
                        cipher_s = {WIDTH{1'b0}};
                        err_s    = 1'b1;
                        done_s   = 1'b1;
                    end else if (EBITS == 0) begin
                        cipher_s = ONE_MOD;
                        err_s    = 1'b0;
                        done_s   = 1'b1;
                    end else begin
                        acc_s   = ONE_W;
                        base_s  = msg;
                        exp_s   = E_W;
                        err_s   = 1'b0;
                        busy_s  = 1'b1;
                        state_s = ST_STEP;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_STEP: begin
                acc_s  = acc_step_s;
                base_s = modmul_f(base_r, base_r);
                exp_s  = exp_r >> 1;
                if ((exp_r >> 1) == {WIDTH{1'b0}}) begin
                    cipher_s = acc_step_s;
                    done_s   = 1'b1;
                    busy_s   = 1'b0;
                    state_s  = ST_IDLE;
                end else begin
                    state_s = ST_STEP;
                end
            end
            default: begin
                state_s = ST_IDLE;
                busy_s  = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_rsa_encrypt_core.sv
// Directed self-checking bench for rsa_encrypt_core (E=7, N=143) plus E=0 and E=1 instances.
module tb_rsa_encrypt_core;

    logic       clk;
    logic       rst;
    logic       start, start0, start1;
    logic [7:0] msg, msg0, msg1;
    logic       busy, busy0, busy1;
    logic       done, done0, done1;
    logic [7:0] cipher, cipher0, cipher1;
    logic       err, err0, err1;

    int n_checks = 0;
    int n_fail   = 0;

    rsa_encrypt_core dut (
        .clk(clk), .rst(rst), .start(start), .msg(msg),
        .busy(busy), .done(done), .cipher(cipher), .err(err)
    );

    rsa_encrypt_core #(.WIDTH(8), .E(0), .N(143)) dut_e0 (
        .clk(clk), .rst(rst), .start(start0), .msg(msg0),
        .busy(busy0), .done(done0), .cipher(cipher0), .err(err0)
    );

    rsa_encrypt_core #(.WIDTH(8), .E(1), .N(143)) dut_e1 (
        .clk(clk), .rst(rst), .start(start1), .msg(msg1),
        .busy(busy1), .done(done1), .cipher(cipher1), .err(err1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference exponentiation by plain repeated multiplication.
    function automatic int unsigned powmod(input int unsigned b, input int unsigned e,
                                           input int unsigned n);
        int unsigned r;
        r = 1 % n;
        for (int i = 0; i < e; i++) r = (r * b) % n;
        return r;
    endfunction

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; start0 = 1'b0; start1 = 1'b0;
        msg = 8'd0; msg0 = 8'd0; msg1 = 8'd0;
        tick(); tick();
        rst = 1'b0;
        n_checks++;
        if ({busy, done, cipher, err} !== 11'd0) begin
            n_fail++; $display("FAIL reset_main: got busy=%b done=%b cipher=%0d err=%b, want all 0", busy, done, cipher, err);
        end
        n_checks++;
        if ({busy0, done0, cipher0, err0, busy1, done1, cipher1, err1} !== 22'd0) begin
            n_fail++; $display("FAIL reset_param: E0 %b%b%0d%b E1 %b%b%0d%b, want all 0", busy0, done0, cipher0, err0, busy1, done1, cipher1, err1);
        end
    endtask

    task automatic test_basic();
        start = 1'b1; msg = 8'd5;
        tick();                      // edge T0
        start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            n_checks++;
            if (busy !== 1'b1 || done !== 1'b0) begin
                n_fail++; $display("FAIL basic_busy[%0d]: busy=%b done=%b, want busy=1 done=0", k, busy, done);
            end
            tick();
        end
        n_checks++;
        if (done !== 1'b1 || cipher !== 8'd47 || err !== 1'b0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL basic_done: done=%b cipher=%0d err=%b busy=%b, want 1 47 0 0", done, cipher, err, busy);
        end
        tick();
        n_checks++;
        if (done !== 1'b0 || cipher !== 8'd47) begin
            n_fail++; $display("FAIL basic_pulse: done=%b cipher=%0d, want done=0 cipher=47", done, cipher);
        end
    endtask

    task automatic test_back_to_back();
        int n;
        logic [7:0] vals [3];
        logic [7:0] exps [3];
        vals = '{8'd2, 8'd10, 8'd142};
        exps = '{8'd128, 8'd10, 8'd142};
        start = 1'b1;
        for (int v = 0; v < 3; v++) begin
            msg = vals[v];
            tick();                  // accepted here (IDLE or done cycle)
            n = 0;
            while (done !== 1'b1 && n < 10) begin
                tick(); n++;
            end
            n_checks++;
            if (n !== 3 || cipher !== exps[v] || err !== 1'b0) begin
                n_fail++; $display("FAIL b2b[%0d]: latency=%0d cipher=%0d err=%b, want 3 %0d 0", v, n, cipher, err, exps[v]);
            end
        end
        start = 1'b0;
        tick();
    endtask

    task automatic test_out_of_range();
        bit saw_busy;
        start = 1'b1; msg = 8'd143;
        tick();
        start = 1'b0;
        saw_busy = busy;
        n_checks++;
        if (done !== 1'b1 || err !== 1'b1 || cipher !== 8'd0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL oor_done: done=%b err=%b cipher=%0d busy=%b, want 1 1 0 0", done, err, cipher, busy);
        end
        tick();
        saw_busy = saw_busy | busy;
        n_checks++;
        if (done !== 1'b0 || err !== 1'b1 || saw_busy) begin
            n_fail++; $display("FAIL oor_hold: done=%b err=%b saw_busy=%b, want 0 1 0", done, err, saw_busy);
        end
        start = 1'b1; msg = 8'd0;
        tick();
        start = 1'b0;
        tick(); tick(); tick();
        n_checks++;
        if (done !== 1'b1 || cipher !== 8'd0 || err !== 1'b0) begin
            n_fail++; $display("FAIL oor_clear: done=%b cipher=%0d err=%b, want 1 0 0", done, cipher, err);
        end
        tick();
    endtask

    task automatic test_disturb();
        start = 1'b1; msg = 8'd5;
        tick();
        msg = 8'd99; tick();
        start = 1'b0; msg = 8'd3; tick();
        start = 1'b1; msg = 8'd200;
        n_checks++;
        if (done !== 1'b0 || busy !== 1'b1) begin
            n_fail++; $display("FAIL disturb_busy: done=%b busy=%b, want 0 1", done, busy);
        end
        tick();
        start = 1'b0;
        n_checks++;
        if (done !== 1'b1 || cipher !== 8'd47 || err !== 1'b0) begin
            n_fail++; $display("FAIL disturb_result: done=%b cipher=%0d err=%b, want 1 47 0", done, cipher, err);
        end
        tick();
    endtask

    task automatic test_mid_reset();
        bit saw_done;
        start = 1'b1; msg = 8'd10;
        tick();                      // T0
        start = 1'b0;
        tick();                      // T0+1
        rst = 1'b1;
        tick();                      // T0+2
        rst = 1'b0;
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0 || cipher !== 8'd0 || err !== 1'b0) begin
            n_fail++; $display("FAIL midrst_state: busy=%b done=%b cipher=%0d err=%b, want 0 0 0 0", busy, done, cipher, err);
        end
        saw_done = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            saw_done = saw_done | done | busy;
        end
        n_checks++;
        if (saw_done || cipher !== 8'd0) begin
            n_fail++; $display("FAIL midrst_quiet: done/busy seen=%b cipher=%0d, want 0 0", saw_done, cipher);
        end
    endtask

    task automatic test_round_trip();
        int n;
        int unsigned rec;
        for (int m = 0; m < 143; m++) begin
            start = 1'b1; msg = 8'(m);
            tick();
            start = 1'b0;
            n = 0;
            while (done !== 1'b1 && n < 10) begin
                tick(); n++;
            end
            rec = powmod(32'(cipher), 103, 143);
            n_checks++;
            if (n !== 3 || 32'(cipher) !== powmod(m, 7, 143) || rec !== m) begin
                n_fail++; $display("FAIL round_trip[%0d]: latency=%0d cipher=%0d recovered=%0d, want 3 %0d %0d", m, n, cipher, rec, powmod(m, 7, 143), m);
            end
            tick();
        end
    endtask

    task automatic test_param_e0();
        start0 = 1'b1; msg0 = 8'd5;
        tick();
        start0 = 1'b0;
        n_checks++;
        if (done0 !== 1'b1 || cipher0 !== 8'd1 || err0 !== 1'b0 || busy0 !== 1'b0) begin
            n_fail++; $display("FAIL e0_done: done=%b cipher=%0d err=%b busy=%b, want 1 1 0 0", done0, cipher0, err0, busy0);
        end
        tick();
        n_checks++;
        if (done0 !== 1'b0) begin
            n_fail++; $display("FAIL e0_pulse: done=%b, want 0", done0);
        end
        start0 = 1'b1; msg0 = 8'd142;
        tick();
        start0 = 1'b0;
        n_checks++;
        if (done0 !== 1'b1 || cipher0 !== 8'd1) begin
            n_fail++; $display("FAIL e0_msg142: done=%b cipher=%0d, want 1 1", done0, cipher0);
        end
        tick();
    endtask

    task automatic test_param_e1();
        start1 = 1'b1; msg1 = 8'd77;
        tick();
        start1 = 1'b0;
        n_checks++;
        if (busy1 !== 1'b1 || done1 !== 1'b0) begin
            n_fail++; $display("FAIL e1_busy: busy=%b done=%b, want 1 0", busy1, done1);
        end
        tick();
        n_checks++;
        if (done1 !== 1'b1 || cipher1 !== 8'd77 || busy1 !== 1'b0) begin
            n_fail++; $display("FAIL e1_done: done=%b cipher=%0d busy=%b, want 1 77 0", done1, cipher1, busy1);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_out_of_range();
        test_disturb();
        test_mid_reset();
        test_round_trip();
        test_param_e0();
        test_param_e1();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
